// File: rtl/regfile_ctrl.sv
// Register-file port arbiter: passes datapath traffic through, runs snapshot
// store/restore sequences and slots single-cycle debug accesses in between.
module regfile_ctrl #(
  parameter int SR_CYCLES    = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  input  logic [4:0]  cpu_raddr2,
  input  logic        ctx_save,
  input  logic        ctx_restore,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we3,
  output logic [4:0]  rf_address3,
  output logic [31:0] rf_wdata3,
  output logic [4:0]  rf_address2,
  output logic [1:0]  rf_sr,
  output logic        ctx_busy,
  output logic        ctx_valid,
  output logic        ctx_err,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [2:0] {IDLE, SAVE, RESTORE, HOLD, DBG, ACK} state_t;

  localparam logic [3:0] SR_LAST    = 4'(SR_CYCLES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t      state, state_n;
  logic [3:0]  sr_cnt;
  logic [7:0]  starve;
  logic        save_pend, rest_pend, arm;
  logic        eff_save, eff_rest, armed, is_idle, in_sr, err_n;

  assign eff_save = ctx_save | save_pend;
  assign eff_rest = ctx_restore | rest_pend;
  assign armed    = arm & dbg_req;
  assign is_idle  = (state == IDLE);
  assign in_sr    = (state == SAVE) || (state == RESTORE);

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (eff_save)
          state_n = SAVE;
        else if (eff_rest) begin
          if (ctx_valid) state_n = RESTORE;
          else           err_n   = 1'b1;
        end
        else if (armed && !cpu_we)
          state_n = DBG;
        else if (armed && starve == STARVE_MAX)
          state_n = HOLD;
      end
      SAVE, RESTORE: if (sr_cnt == SR_LAST) state_n = IDLE;
      HOLD:          state_n = DBG;
      DBG:           state_n = ACK;
      ACK:           state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end

  // Port muxing: datapath owns the ports in IDLE, debug owns them in DBG.
  always_comb begin
    rf_we3      = 1'b0;
    rf_address3 = cpu_waddr;
    rf_wdata3   = cpu_wdata;
    rf_address2 = cpu_raddr2;
    if (is_idle)
      rf_we3 = cpu_we;
    else if (state == DBG) begin
      rf_we3      = dbg_we;
      rf_address3 = dbg_addr;
      rf_wdata3   = dbg_wdata;
      rf_address2 = dbg_addr;
    end
    if (reset) rf_we3 = 1'b0;
  end

  assign rf_sr    = (state == SAVE) ? 2'd1 : (state == RESTORE) ? 2'd3 : 2'd0;
  assign ctx_busy = in_sr || (state == HOLD) || (state == DBG);
  assign dbg_gnt  = (state == DBG);
  assign dbg_done = (state == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr_cnt    <= '0;
      starve    <= '0;
      save_pend <= 1'b0;
      rest_pend <= 1'b0;
      arm       <= 1'b0;
      ctx_valid <= 1'b0;
      ctx_err   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state   <= state_n;
      ctx_err <= err_n;
      sr_cnt  <= (in_sr && state_n == state) ? sr_cnt + 4'd1 : 4'd0;

      if (in_sr && state_n == IDLE)
        ctx_valid <= (state == SAVE);

      // A save always consumes a same-cycle restore silently.
      if (is_idle) begin
        if (eff_save) begin
          save_pend <= 1'b0;
          rest_pend <= 1'b0;
        end else if (eff_rest)
          rest_pend <= 1'b0;
      end else begin
        save_pend <= save_pend | ctx_save;
        rest_pend <= rest_pend | ctx_restore;
      end

      if (state == ACK)  arm <= 1'b0;
      else if (!dbg_req) arm <= 1'b1;

      if (state_n == DBG)
        starve <= '0;
      else if (is_idle && armed && state_n != HOLD && starve != STARVE_MAX)
        starve <= starve + 8'd1;

      if (state == DBG) dbg_rdata <= rf_rdata2;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: register-file environment, timer-based reference
// model checked every cycle, directed scenarios with literal expectations.
module tb_regfile_ctrl;
  localparam int SR  = 2;
  localparam int LIM = 8;

  logic        clk, reset;
  logic        cpu_we, ctx_save, ctx_restore, dbg_req, dbg_we;
  logic [4:0]  cpu_waddr, cpu_raddr2, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata, rf_rdata2;
  logic        rf_we3, ctx_busy, ctx_valid, ctx_err, dbg_gnt, dbg_done;
  logic [4:0]  rf_address3, rf_address2;
  logic [31:0] rf_wdata3, dbg_rdata;
  logic [1:0]  rf_sr;

  int total = 0, passed = 0;

  regfile_ctrl #(.SR_CYCLES(SR), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .cpu_raddr2(cpu_raddr2), .ctx_save(ctx_save),
    .ctx_restore(ctx_restore), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .rf_rdata2(rf_rdata2),
    .rf_we3(rf_we3), .rf_address3(rf_address3), .rf_wdata3(rf_wdata3),
    .rf_address2(rf_address2), .rf_sr(rf_sr), .ctx_busy(ctx_busy),
    .ctx_valid(ctx_valid), .ctx_err(ctx_err), .dbg_gnt(dbg_gnt),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // Register file with snapshot storage.
  logic [31:0] rf [32];
  logic [31:0] snap [32];
  assign rf_rdata2 = rf[rf_address2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (rf_sr == 2'd3) rf <= snap;
      else if (rf_we3)   rf[rf_address3] <= rf_wdata3;
      if (rf_sr == 2'd1) snap <= rf;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: remaining snapshot-command cycles plus one-shot debug
  // phase flags; "idle" means nothing is in flight.
  int          m_srl = 0, m_cmd = 0, m_starve = 0;
  bit          m_hold = 0, m_gnt = 0, m_done = 0, m_valid = 0, m_err = 0;
  bit          m_sp = 0, m_rp = 0, m_arm = 0;
  logic [31:0] m_rdata = '0;

  initial forever begin
    bit idle, es, er, armed, took, n_err, n_arm;
    @(negedge clk);
    idle = (m_srl == 0) && !m_hold && !m_gnt && !m_done;
    chk("rf_we3", rf_we3, reset ? 0 : idle ? cpu_we : m_gnt ? dbg_we : 0);
    if (idle || m_gnt) begin
      chk("rf_address3", rf_address3, m_gnt ? dbg_addr : cpu_waddr);
      chk("rf_wdata3", rf_wdata3, m_gnt ? dbg_wdata : cpu_wdata);
      chk("rf_address2", rf_address2, m_gnt ? dbg_addr : cpu_raddr2);
    end
    chk("rf_sr", rf_sr, (m_srl > 0) ? m_cmd : 0);
    chk("ctx_busy", ctx_busy, (m_srl > 0) || m_hold || m_gnt);
    chk("dbg_gnt", dbg_gnt, m_gnt);
    chk("dbg_done", dbg_done, m_done);
    chk("ctx_valid", ctx_valid, m_valid);
    chk("ctx_err", ctx_err, m_err);
    chk("dbg_rdata", dbg_rdata, m_rdata);

    if (reset) begin
      m_srl = 0; m_hold = 0; m_gnt = 0; m_done = 0; m_valid = 0; m_err = 0;
      m_sp = 0; m_rp = 0; m_arm = 0; m_starve = 0; m_rdata = '0;
    end else begin
      es = ctx_save | m_sp;
      er = ctx_restore | m_rp;
      armed = m_arm && dbg_req;
      n_err = 0;
      n_arm = m_done ? 0 : (!dbg_req ? 1 : m_arm);
      if (idle) begin
        took = 0;
        if (es) begin
          m_srl = SR; m_cmd = 1; m_sp = 0; m_rp = 0;
        end else if (er) begin
          m_rp = 0;
          if (m_valid) begin m_srl = SR; m_cmd = 3; end
          else n_err = 1;
        end else if (armed && !cpu_we) begin
          m_gnt = 1; took = 1;
        end else if (armed && m_starve == LIM) begin
          m_hold = 1; took = 1;
        end
        if (armed && !took && m_starve < LIM) m_starve++;
        if (m_gnt) m_starve = 0;
      end else begin
        m_sp |= ctx_save;
        m_rp |= ctx_restore;
        if (m_srl > 0) begin
          m_srl--;
          if (m_srl == 0) m_valid = (m_cmd == 1);
        end else if (m_hold) begin
          m_hold = 0; m_gnt = 1; m_starve = 0;
        end else if (m_gnt) begin
          m_gnt = 0; m_done = 1; m_rdata = rf[dbg_addr];
        end else if (m_done) m_done = 0;
      end
      m_err = n_err;
      m_arm = n_arm;
    end
  end

  bit last_done;
  task automatic step();
    @(negedge clk);
    last_done = dbg_done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1, n3, nb, ne, nsr, gi, di, b9, k;
    reset = 1; cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; cpu_raddr2 = 0;
    ctx_save = 0; ctx_restore = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0;
    dbg_wdata = 0; last_done = 0;
    @(posedge clk); #1;
    step();
    reset = 0;
    #1;
    chk("rst_rf_sr", rf_sr, 0);
    chk("rst_valid", ctx_valid, 0);
    chk("rst_rdata", dbg_rdata, 0);
    step();

    // pass-through write
    cpu_we = 1; cpu_waddr = 5'd1; cpu_wdata = 32'd15;
    #1;
    chk("pt_we", rf_we3, 1);
    chk("pt_addr", rf_address3, 1);
    chk("pt_data", rf_wdata3, 15);
    chk("pt_sr", rf_sr, 0);
    step();
    cpu_we = 0;

    // save then restore
    ctx_save = 1; step(); ctx_save = 0;
    n1 = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (rf_sr == 2'd1) begin n1++; if (ctx_busy) nb++; end
      step();
    end
    chk("save_sr_cycles", n1, 2);
    chk("save_busy", nb, 2);
    chk("save_valid", ctx_valid, 1);
    ctx_restore = 1; step(); ctx_restore = 0;
    n3 = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (rf_sr == 2'd3) n3++;
      step();
    end
    chk("rest_sr_cycles", n3, 2);
    chk("rest_valid", ctx_valid, 0);

    // restore without snapshot, then simultaneous save+restore
    reset = 1; cpu_we = 1;
    #1; chk("rst_we_mask", rf_we3, 0);
    step(); reset = 0; cpu_we = 0; step();
    ctx_restore = 1; step(); ctx_restore = 0;
    ne = 0; nsr = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (ctx_err) ne++; if (rf_sr != 0) nsr++;
      step();
    end
    chk("err_pulses", ne, 1);
    chk("err_no_sr", nsr, 0);
    ctx_save = 1; ctx_restore = 1; step(); ctx_save = 0; ctx_restore = 0;
    n1 = 0; n3 = 0; ne = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (rf_sr == 2'd1) n1++; if (rf_sr == 2'd3) n3++; if (ctx_err) ne++;
      step();
    end
    chk("sr_both_save", n1, 2);
    chk("sr_both_rest", n3, 0);
    chk("sr_both_err", ne, 0);

    // debug write then read back
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
    di = -1; k = 0;
    while (k < 20 && di < 0) begin
      #1; if (dbg_done) di = k;
      step(); k++;
    end
    chk("dbgw_done_cycle", di, 2);
    dbg_we = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (dbg_gnt) nb++;
      step();
    end
    chk("dbg_rearm_block", nb, 0);
    dbg_req = 0; step(); dbg_req = 1;
    di = -1; k = 0;
    while (k < 20 && di < 0) begin
      #1; if (dbg_done) begin di = k; chk("dbg_readback", dbg_rdata, 32'hDEADBEEF); end
      step(); k++;
    end
    chk("dbgr_done_cycle", di, 2);
    dbg_req = 0; step();

    // starvation forced stall
    cpu_we = 1; cpu_waddr = 5'd7; dbg_req = 1;
    gi = -1; di = -1; b9 = 0; k = 0;
    while (k < 20 && di < 0) begin
      #1;
      if (dbg_gnt && gi < 0) gi = k;
      if (dbg_done) di = k;
      if (k == 9) b9 = ctx_busy && !dbg_gnt;
      step(); k++;
    end
    chk("starve_gnt_cycle", gi, 10);
    chk("starve_done_cycle", di, 11);
    chk("starve_hold_busy", b9, 1);
    dbg_req = 0; cpu_we = 0; step();

    // save latched during debug, reset during the save
    dbg_req = 1; #1; step();
    ctx_save = 1; #1; chk("lat_gnt", dbg_gnt, 1); step();
    ctx_save = 0; #1; chk("lat_done", dbg_done, 1); step();
    dbg_req = 0; #1; chk("lat_idle_sr", rf_sr, 0); step();
    #1; chk("lat_save_sr", rf_sr, 1); chk("lat_valid_pre", ctx_valid, 1); step();
    reset = 1; #1; chk("rstmid_sr", rf_sr, 1); step();
    reset = 0; #1; chk("rstmid_sr0", rf_sr, 0); chk("rstmid_valid", ctx_valid, 0);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit burst;
      burst = ((c / 60) % 3) == 1;
      reset = ($urandom_range(0, 299) == 0);
      cpu_we = burst ? 1'b1 : ($urandom_range(0, 3) == 0);
      cpu_waddr = 5'($urandom); cpu_wdata = $urandom; cpu_raddr2 = 5'($urandom);
      ctx_save = ($urandom_range(0, 39) == 0);
      ctx_restore = ($urandom_range(0, 29) == 0);
      if (dbg_req && last_done) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 5) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      end
      step();
      if (reset) dbg_req = 0;
    end
    reset = 0; step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
